prbs_checker: RTL and testbench
===============================

# prbs_checker

Serial PRBS receiver/checker for the XNOR-feedback LFSR stream (default PRBS7, x^7 + x^6 + 1, XNOR form). It consumes one bit per valid beat and self-synchronises its local LFSR to the incoming stream. It then flags every bit that differs from the predicted sequence and keeps a saturating error count. It sits at the far end of a serial link or loopback path, opposite the XNOR-LFSR pattern generator, as the lab's bit-error-rate test block.

## Interface
Parameters:
- TAP_A, 7, long tap; also the LFSR length N.
- TAP_B, 6, short tap (TAP_B < TAP_A).
- LOCK_COUNT, 8, consecutive matches in HUNT required to declare lock.
- LOSS_THRESH, 4, consecutive mismatches in LOCKED that force return to HUNT.
- ERR_WIDTH, 16, width of the error counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit is valid this cycle; nothing advances when low.
- in_bit  input  1  received serial bit.
- clear  input  1  synchronous clear of err_count; lock state is unaffected.
- locked  output  1  registered; high while in LOCKED.
- err  output  1  registered one-cycle pulse per mismatching beat while LOCKED.
- err_count  output  ERR_WIDTH  registered; saturating mismatch count, counted while LOCKED only.

## Operation
Shift register and prediction:
- sr[N-1:0] holds the last N bits; sr[0] is the newest.
- Predicted bit: p = ~(sr[TAP_A-1] ^ sr[TAP_B-1]).
- The all-ones value is the XNOR lockup state.

States (advance only on in_valid beats):
- SEED: shift in_bit into sr and count beats. After N beats, go to HUNT with run = 0.
- HUNT: shift in_bit into sr (self-sync).
  - If sr is all-ones: treat the beat as a non-match (run = 0), so a stuck-high line never locks.
  - Else if in_bit == p: run += 1. When run reaches LOCK_COUNT, go to LOCKED with miss = 0.
  - Else: run = 0.
- LOCKED: shift p into sr (free-running), never in_bit, so one line error counts once.
  - Mismatch (in_bit != p): err = 1, err_count += 1 (saturates at all-ones), miss += 1. When miss reaches LOSS_THRESH, go to HUNT with run = 0.
  - Match: miss = 0.

Outputs and counter rules:
- err is 0 on every cycle without a LOCKED mismatch beat, including in_valid-low cycles.
- clear wins over a same-cycle increment: err_count becomes 0, and err still pulses.
- Losing lock does not clear err_count.

## Timing
- Reset (async assert, sync release): state SEED, sr = 0, run = 0, miss = 0, locked = 0, err = 0, err_count = 0.
- Reset asserted mid-operation: all outputs drop immediately. Relock needs N + LOCK_COUNT fresh valid beats.
- Latency: err and err_count update on the clock edge that samples the offending beat, visible the following cycle.
- locked rises on the edge sampling the LOCK_COUNT-th consecutive HUNT match. It falls on the edge sampling the LOSS_THRESH-th consecutive mismatch; that beat still pulses err and counts.
- Minimum time to lock from reset: N + LOCK_COUNT valid beats (15 with defaults). in_valid gaps stretch wall-clock time only.
- The input is registered-to-registered only. There is no combinational path from in_bit to any output.

## Structure
- Shared header prbs_defs.vh holds:
  - state encodings (SEED, HUNT, LOCKED);
  - default TAP_A/TAP_B;
  - LOCK_COUNT/LOSS_THRESH defaults.
- Sub-module prbs_lfsr holds sr, the XNOR feedback p, and a load-select (external bit vs. own p). It is reused unchanged by the future generator.
- prbs_checker holds the state machine, the run/miss counters, and the error counter.

## Test plan
- Reset, then a generator seeded with all-zeros (first bits 1111110…) for 200 beats, in_valid = 1: locked = 1 after beat 15, err never pulses, err_count = 0.
- Locked; invert beat 40 only: single err pulse, err_count = 1, locked stays 1.
- Locked; invert 3 consecutive beats, then clean: err_count = 3, locked stays 1. Next, invert 4 consecutive beats: err_count = 7, locked falls, and relocks 8 beats later.
- in_bit held at 1 for 300 beats after reset: locked stays 0, err_count = 0.
- Repeat the first scenario with in_valid randomly low 50% of cycles: identical lock beat and counts.
- Assert clear on the same cycle as an injected error: err pulses and err_count = 0. Assert rst_n low mid-lock for 1 cycle: locked, err_count = 0, and relock after 15 valid beats.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// rtl/prbs_checker_pkg.sv - shared state encodings and default parameters for the PRBS blocks
package prbs_checker_pkg;

   // Checker state encoding
   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } prbs_state_e;

   // Default PRBS7 (x^7 + x^6 + 1) taps and lock/loss thresholds
   localparam int DEF_TAP_A       = 7;
   localparam int DEF_TAP_B       = 6;
   localparam int DEF_LOCK_COUNT  = 8;
   localparam int DEF_LOSS_THRESH = 4;

endpackage

// File: rtl/prbs_lfsr.sv
// rtl/prbs_lfsr.sv - XNOR-feedback LFSR with selectable load of an external bit or its own prediction
module prbs_lfsr
   import prbs_checker_pkg::*;
#(
   parameter int TAP_A = DEF_TAP_A,
   parameter int TAP_B = DEF_TAP_B
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             load_ext,
   input  logic             ext_bit,
   output logic [TAP_A-1:0] sr,
   output logic             p
);

   // Prediction of the next bit from the current register contents
   assign p = ~(sr[TAP_A-1] ^ sr[TAP_B-1]);

   // Shift register: newest bit enters at sr[0]; either the received bit or the own prediction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (shift_en) begin
         sr <= {sr[TAP_A-2:0], (load_ext ? ext_bit : p)};
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS checker with lock tracking and saturating error count
module prbs_checker
   import prbs_checker_pkg::*;
#(
   parameter int TAP_A       = DEF_TAP_A,
   parameter int TAP_B       = DEF_TAP_B,
   parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
   parameter int LOSS_THRESH = DEF_LOSS_THRESH,
   parameter int ERR_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 in_bit,
   input  logic                 clear,
   output logic                 locked,
   output logic                 err,
   output logic [ERR_WIDTH-1:0] err_count
);

   localparam int N      = TAP_A;
   localparam int SEED_W = $clog2(N + 1);
   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(LOSS_THRESH + 1);

   prbs_state_e       state, state_d;
   logic [SEED_W-1:0] seed_cnt, seed_cnt_d;
   logic [RUN_W-1:0]  run, run_d;
   logic [MISS_W-1:0] miss, miss_d;
   logic              err_d;
   logic              inc;
   logic              load_ext;
   logic [N-1:0]      sr;
   logic              p;
   logic              all_ones;
   logic              match;

   prbs_lfsr #(
      .TAP_A (TAP_A),
      .TAP_B (TAP_B)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (in_valid),
      .load_ext (load_ext),
      .ext_bit  (in_bit),
      .sr       (sr),
      .p        (p)
   );

   assign all_ones = &sr;
   assign match    = (in_bit == p);

   // Next-state logic: seed the register, hunt for a clean run, then free-run and count mismatches
   always_comb begin
      state_d    = state;
      seed_cnt_d = seed_cnt;
      run_d      = run;
      miss_d     = miss;
      err_d      = 1'b0;
      inc        = 1'b0;
      load_ext   = 1'b1;
      if (in_valid) begin
         case (state)
            ST_SEED: begin
               if (seed_cnt == SEED_W'(N - 1)) begin
                  state_d    = ST_HUNT;
                  seed_cnt_d = '0;
                  run_d      = '0;
               end else begin
                  seed_cnt_d = seed_cnt + 1'b1;
               end
            end
            ST_HUNT: begin
               // An all-ones register is the XNOR lockup; a stuck-high line must never lock
               if (all_ones) begin
                  run_d = '0;
               end else if (match) begin
                  if (run == RUN_W'(LOCK_COUNT - 1)) begin
                     state_d = ST_LOCKED;
                     run_d   = '0;
                     miss_d  = '0;
                  end else begin
                     run_d = run + 1'b1;
                  end
               end else begin
                  run_d = '0;
               end
            end
            ST_LOCKED: begin
               // Free-run on the prediction so one line error is counted only once
               load_ext = 1'b0;
               if (!match) begin
                  err_d = 1'b1;
                  inc   = 1'b1;
                  if (miss == MISS_W'(LOSS_THRESH - 1)) begin
                     state_d = ST_HUNT;
                     run_d   = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss + 1'b1;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: begin
               state_d = ST_SEED;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_SEED;
         seed_cnt  <= '0;
         run       <= '0;
         miss      <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         state    <= state_d;
         seed_cnt <= seed_cnt_d;
         run      <= run_d;
         miss     <= miss_d;
         locked   <= (state_d == ST_LOCKED);
         err      <= err_d;
         if (clear) begin
            err_count <= '0;
         end else if (inc && !(&err_count)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - randomized self-checking bench for prbs_checker against a history-based model
`timescale 1ns/1ps
module tb_prbs_checker;

   localparam int N   = 7;
   localparam int TA  = 7;
   localparam int TB  = 6;
   localparam int LC  = 8;
   localparam int LT  = 4;
   localparam int EW  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_bit = 1'b0;
   logic          clear = 1'b0;
   logic          locked;
   logic          err;
   logic [EW-1:0] err_count;

   int n_tests = 0;
   int n_fail  = 0;

   prbs_checker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .clear     (clear),
      .locked    (locked),
      .err       (err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // checking task
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference model: bit history as a time series, mode as plain integers
   int   m_mode;     // 0 seed, 1 hunt, 2 locked
   int   m_beats, m_run, m_miss, m_cnt;
   bit   m_err;
   bit   m_hist[$];  // m_hist[$] is the most recent bit

   function automatic void model_reset();
      m_mode = 0; m_beats = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_err = 0;
      m_hist.delete();
      for (int i = 0; i < N; i++) m_hist.push_back(1'b0);
   endfunction

   function automatic void model_step(input bit v, input bit b, input bit c);
      int  sz, ones;
      bit  pred;
      m_err = 0;
      if (v) begin
         sz   = m_hist.size();
         pred = ~(m_hist[sz-TA] ^ m_hist[sz-TB]);
         ones = 0;
         for (int k = 1; k <= N; k++) ones += m_hist[sz-k];
         if (m_mode == 0) begin
            m_hist.push_back(b);
            m_beats++;
            if (m_beats == N) begin m_mode = 1; m_run = 0; end
         end else if (m_mode == 1) begin
            m_hist.push_back(b);
            if (ones == N) m_run = 0;
            else if (b == pred) begin
               m_run++;
               if (m_run == LC) begin m_mode = 2; m_miss = 0; end
            end else m_run = 0;
         end else begin
            m_hist.push_back(pred);
            if (b != pred) begin
               m_err = 1;
               if (m_cnt < (1 << EW) - 1) m_cnt++;
               m_miss++;
               if (m_miss == LT) begin m_mode = 1; m_run = 0; end
            end else m_miss = 0;
         end
         if (m_hist.size() > 64) void'(m_hist.pop_front());
      end
      if (c) m_cnt = 0;
   endfunction

   // generator and scenario bookkeeping
   logic [6:0] gen_sr;
   int g_beat, lock_beat, last_rise, last_fall, err_pulses;
   bit prev_locked;

   task automatic gen_next(output bit b);
      b = ~(gen_sr[6] ^ gen_sr[5]);
      gen_sr = {gen_sr[5:0], b};
   endtask

   function automatic void clr_stats();
      lock_beat = 0; last_rise = 0; last_fall = 0; err_pulses = 0;
   endfunction

   task automatic beat(input bit v, input bit b, input bit c);
      in_valid = v; in_bit = b; clear = c;
      model_step(v, b, c);
      if (v) g_beat++;
      @(posedge clk);
      #1;
      check("locked", locked, (m_mode == 2));
      check("err", err, m_err);
      check("err_count", err_count, m_cnt);
      if (locked && !prev_locked) begin
         if (lock_beat == 0) lock_beat = g_beat;
         last_rise = g_beat;
      end
      if (!locked && prev_locked) last_fall = g_beat;
      if (err) err_pulses++;
      prev_locked = locked;
      in_valid = 0; clear = 0;
   endtask

   task automatic do_reset();
      rst_n = 0; in_valid = 0; in_bit = 0; clear = 0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_locked", locked, 0);
      check("rst_err", err, 0);
      check("rst_cnt", err_count, 0);
      rst_n = 1;
      model_reset();
      g_beat = 0; prev_locked = 0; gen_sr = '0;
      clr_stats();
   endtask

   task automatic send_gen(input int n, input int inv_at, input int inv_len, input int gap_pct);
      bit b;
      for (int i = 1; i <= n; i++) begin
         while (int'($urandom_range(99)) < gap_pct) beat(0, 1'($urandom), 0);
         gen_next(b);
         if (i >= inv_at && i < inv_at + inv_len) b = ~b;
         beat(1, b, 0);
      end
   endtask

   initial begin
      bit b;
      model_reset();
      do_reset();

      // clean stream from an all-zeros generator
      send_gen(200, 0, 0, 0);
      check("a_lock_beat", lock_beat, 15);
      check("a_err_pulses", err_pulses, 0);
      check("a_cnt", err_count, 0);
      check("a_locked", locked, 1);

      // single inverted beat
      clr_stats();
      send_gen(60, 40, 1, 0);
      check("b_err_pulses", err_pulses, 1);
      check("b_cnt", err_count, 1);
      check("b_fall", last_fall, 0);

      // clear with no beat, then three then four consecutive errors
      beat(0, 0, 1);
      check("c_cleared", err_count, 0);
      clr_stats();
      send_gen(20, 5, 3, 0);
      check("c3_cnt", err_count, 3);
      check("c3_locked", locked, 1);
      check("c3_fall", last_fall, 0);
      clr_stats();
      send_gen(30, 10, 4, 0);
      check("c4_cnt", err_count, 7);
      check("c4_pulses", err_pulses, 4);
      check("c4_fell", (last_fall > 0), 1);
      check("c4_relock_gap", last_rise - last_fall, 8);
      check("c4_locked", locked, 1);

      // stuck-high line never locks
      do_reset();
      for (int i = 0; i < 300; i++) beat(1, 1, 0);
      check("d_lock_beat", lock_beat, 0);
      check("d_cnt", err_count, 0);

      // clean stream with 50% valid gaps
      do_reset();
      send_gen(200, 0, 0, 50);
      check("e_lock_beat", lock_beat, 15);
      check("e_err_pulses", err_pulses, 0);
      check("e_cnt", err_count, 0);

      // clear in the same cycle as an injected error
      send_gen(10, 3, 1, 0);
      check("f_pre_cnt", err_count, 1);
      gen_next(b);
      beat(1, ~b, 1);
      check("f_err", err, 1);
      check("f_cnt", err_count, 0);
      send_gen(5, 0, 0, 0);

      // one-cycle asynchronous reset while locked
      check("g_pre_locked", locked, 1);
      send_gen(3, 1, 2, 0);
      #2;
      rst_n = 0;
      #1;
      check("g_async_locked", locked, 0);
      check("g_async_cnt", err_count, 0);
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();
      g_beat = 0; prev_locked = 0; clr_stats();
      send_gen(30, 0, 0, 20);
      check("g_lock_beat", lock_beat, 15);
      check("g_cnt", err_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
